// File: rtl/qpd_lockin_demod_if.sv
// Bus bundle for the QPD lock-in demodulator: sample inputs, references, results and status.
// The master drives samples and control; the slave (demodulator) returns I/Q results and status.
interface qpd_lockin_demod_if #(
    parameter int NUM_BITS = 24,
    parameter int NUM_CH   = 4
);
    logic                           tick_i;
    logic                           sync_i;
    logic [NUM_CH*NUM_BITS-1:0]     sig_i;
    logic [NUM_BITS-1:0]            sin_i;
    logic [NUM_BITS-1:0]            cos_i;
    logic                           clear_overrun_i;
    logic [2*NUM_CH*NUM_BITS-1:0]   iq_o;
    logic                           valid_o;
    logic                           busy_o;
    logic                           overrun_o;

    modport master (
        output tick_i, sync_i, sig_i, sin_i, cos_i, clear_overrun_i,
        input  iq_o, valid_o, busy_o, overrun_o
    );

    modport slave (
        input  tick_i, sync_i, sig_i, sin_i, cos_i, clear_overrun_i,
        output iq_o, valid_o, busy_o, overrun_o
    );
endinterface

// File: rtl/qpd_lockin_demod.sv
// Multi-channel lock-in demodulator: one shared multiplier walks 2*NUM_CH I/Q slots per tick,
// accumulates over 2^DECIM_LOG2 ticks and dumps the mean. Define LOCKIN_ROUND_EN for round-half-up dumps.
//
// state | meaning
// IDLE  | waiting for tick_i; latches sig/sin/cos on tick
// MAC   | one slot per cycle into the registered product, accumulate previous slot
// DRAIN | accumulate last slot, advance decimation counter
// DUMP  | publish scaled accumulators, clear them, pulse valid_o
module qpd_lockin_demod #(
    parameter int NUM_BITS   = 24,
    parameter int NUM_CH     = 4,
    parameter int DECIM_LOG2 = 6
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    qpd_lockin_demod_if.slave bus
);
    localparam int NSLOT    = 2 * NUM_CH;
    localparam int SW       = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int PW       = 2 * NUM_BITS;
    localparam int ACC_BITS = 2 * NUM_BITS + DECIM_LOG2;
    localparam int SH       = NUM_BITS + DECIM_LOG2;
`ifdef LOCKIN_ROUND_EN
    localparam logic signed [ACC_BITS-1:0] RND = ACC_BITS'(1) << (SH - 1);
`else
    localparam logic signed [ACC_BITS-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, DUMP} state_t;

    state_t                          state;
    logic [SW-1:0]                   slot;
    logic [NUM_CH*NUM_BITS-1:0]      sig_lat;
    logic signed [NUM_BITS-1:0]      sin_lat;
    logic signed [NUM_BITS-1:0]      cos_lat;
    logic signed [PW-1:0]            prod;
    logic [SW-1:0]                   prod_slot;
    logic                            prod_vld;
    logic signed [ACC_BITS-1:0]      acc [NSLOT];
    logic [DECIM_LOG2-1:0]           smp_cnt;
    logic [NSLOT*NUM_BITS-1:0]       iq_q;
    logic                            valid_q;
    logic                            overrun_q;

    logic signed [NUM_BITS-1:0]      sel_sig;
    logic signed [NUM_BITS-1:0]      sel_ref;
    logic signed [PW-1:0]            prod_d;
    logic [NSLOT*NUM_BITS-1:0]       dump_val;
    logic                            busy;

    assign busy = (state != IDLE);

    always_comb begin
        sel_sig = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (SW'(k) == (slot >> 1)) sel_sig = sig_lat[k*NUM_BITS +: NUM_BITS];
        end
        sel_ref = slot[0] ? cos_lat : sin_lat;
        prod_d  = PW'(sel_sig) * PW'(sel_ref);
    end

    // Mean over 2^DECIM_LOG2 samples, rescaled by 2^-NUM_BITS; the top NUM_BITS always hold it.
    for (genvar g = 0; g < NSLOT; g++) begin : g_dump
        assign dump_val[g*NUM_BITS +: NUM_BITS] = NUM_BITS'((acc[g] + RND) >>> SH);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            slot      <= '0;
            sig_lat   <= '0;
            sin_lat   <= '0;
            cos_lat   <= '0;
            prod      <= '0;
            prod_slot <= '0;
            prod_vld  <= 1'b0;
            smp_cnt   <= '0;
            iq_q      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NSLOT; i++) acc[i] <= '0;
        end else begin
            valid_q  <= 1'b0;
            prod_vld <= 1'b0;

            // A tick swallowed by sync is not an overrun; set beats clear otherwise.
            if (!bus.sync_i && bus.tick_i && busy) overrun_q <= 1'b1;
            else if (bus.clear_overrun_i)          overrun_q <= 1'b0;

            if (prod_vld)
                acc[prod_slot] <= acc[prod_slot] + {{DECIM_LOG2{prod[PW-1]}}, prod};

            if (bus.sync_i) begin
                state   <= IDLE;
                smp_cnt <= '0;
                for (int i = 0; i < NSLOT; i++) acc[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.tick_i) begin
                            sig_lat <= bus.sig_i;
                            sin_lat <= bus.sin_i;
                            cos_lat <= bus.cos_i;
                            slot    <= '0;
                            state   <= MAC;
                        end
                    end
                    MAC: begin
                        prod      <= prod_d;
                        prod_slot <= slot;
                        prod_vld  <= 1'b1;
                        if (slot == SW'(NSLOT - 1)) state <= DRAIN;
                        else                        slot  <= slot + 1'b1;
                    end
                    DRAIN: begin
                        if (smp_cnt == '1) begin
                            smp_cnt <= '0;
                            state   <= DUMP;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                            state   <= IDLE;
                        end
                    end
                    DUMP: begin
                        iq_q    <= dump_val;
                        valid_q <= 1'b1;
                        for (int i = 0; i < NSLOT; i++) acc[i] <= '0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.iq_o      = iq_q;
    assign bus.valid_o   = valid_q;
    assign bus.busy_o    = busy;
    assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_qpd_lockin_demod.sv
// Directed + random bench for qpd_lockin_demod (NUM_CH=2, DECIM_LOG2=2); expected dumps are
// queued from an arithmetic model when ticks are driven and popped when valid_o fires.
module tb_qpd_lockin_demod;
    localparam int NB  = 24;
    localparam int NC  = 2;
    localparam int DL  = 2;
    localparam int NS  = 2 * NC;
    localparam int SH  = NB + DL;
    localparam int LAT = 2 * NC + 3;
    localparam int W   = NS * NB;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    qpd_lockin_demod_if #(.NUM_BITS(NB), .NUM_CH(NC)) bus ();
    qpd_lockin_demod #(.NUM_BITS(NB), .NUM_CH(NC), .DECIM_LOG2(DL)) dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .bus     (bus)
    );

    int vec_cnt   = 0;
    int miss_cnt  = 0;
    int cyc       = 0;
    int valid_cnt = 0;
    longint acc_m [NS];
    int cnt_m;
    logic [W-1:0] exp_q [$];
    int           cyc_q [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) acc_m[s] = 0;
        cnt_m = 0;
    endtask

    task automatic model_sample(input logic signed [NB-1:0] s0, input logic signed [NB-1:0] s1,
                                input logic signed [NB-1:0] sn, input logic signed [NB-1:0] cs,
                                input int drive_cyc);
        logic [W-1:0] e;
        longint v;
        acc_m[0] += longint'(s0) * longint'(sn);
        acc_m[1] += longint'(s0) * longint'(cs);
        acc_m[2] += longint'(s1) * longint'(sn);
        acc_m[3] += longint'(s1) * longint'(cs);
        cnt_m++;
        if (cnt_m == (1 << DL)) begin
            for (int s = 0; s < NS; s++) begin
                v = acc_m[s];
`ifdef LOCKIN_ROUND_EN
                v = v + (longint'(1) <<< (SH - 1));
`endif
                v = v >>> SH;
                e[s*NB +: NB] = v[NB-1:0];
            end
            exp_q.push_back(e);
            cyc_q.push_back(drive_cyc + LAT);
            model_clear();
        end
    endtask

    // Drives one tick cycle at the current negedge; returns at the next negedge.
    task automatic apply_tick(input logic [NB-1:0] s0, input logic [NB-1:0] s1,
                              input logic [NB-1:0] sn, input logic [NB-1:0] cs,
                              input bit accept, input bit do_sync, input bit do_clr);
        bus.sig_i           = {s1, s0};
        bus.sin_i           = sn;
        bus.cos_i           = cs;
        bus.tick_i          = 1'b1;
        bus.sync_i          = do_sync;
        bus.clear_overrun_i = do_clr;
        if (accept) model_sample(s0, s1, sn, cs, cyc);
        @(negedge clk_i);
        bus.tick_i          = 1'b0;
        bus.sync_i          = 1'b0;
        bus.clear_overrun_i = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic pulse_sync();
        bus.sync_i = 1'b1;
        model_clear();
        @(negedge clk_i);
        bus.sync_i = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_overrun_i = 1'b1;
        @(negedge clk_i);
        bus.clear_overrun_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (bus.valid_o === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_valid", W'(bus.valid_o), '0);
            end else begin
                check("iq_dump", bus.iq_o, exp_q.pop_front());
                check("valid_cycle", W'(cyc), W'(cyc_q.pop_front()));
            end
        end
    end

    initial begin
        int vc0;
        logic [NB-1:0] r0, r1, rs, rc;
        bus.tick_i = 1'b0; bus.sync_i = 1'b0; bus.clear_overrun_i = 1'b0;
        bus.sig_i = '0; bus.sin_i = '0; bus.cos_i = '0;
        model_clear();
        #1 reset_ni = 1'b0;
        wait_cyc(2);
        check("rst_iq", bus.iq_o, '0);
        check("rst_valid", W'(bus.valid_o), '0);
        check("rst_busy", W'(bus.busy_o), '0);
        check("rst_overrun", W'(bus.overrun_o), '0);
        reset_ni = 1'b1;
        wait_cyc(2);

        // Basic I/Q
        for (int i = 0; i < 4; i++) begin
            apply_tick(24'h400000, 24'hC00000, 24'h400000, 24'h000000, 1'b1, 1'b0, 1'b0);
            if (i == 0) check("busy_in_mac", W'(bus.busy_o), W'(1));
            wait_cyc(9);
        end
        check("basic_iq_literal", bus.iq_o, {24'h000000, 24'hF00000, 24'h000000, 24'h100000});

        // Reset mid-MAC discards the sample and zeroes everything
        apply_tick(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0, 1'b0, 1'b0);
        check("busy_before_reset", W'(bus.busy_o), W'(1));
        reset_ni = 1'b0;
        #1;
        check("midmac_rst_iq", bus.iq_o, '0);
        check("midmac_rst_valid", W'(bus.valid_o), '0);
        check("midmac_rst_busy", W'(bus.busy_o), '0);
        check("midmac_rst_overrun", W'(bus.overrun_o), '0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        model_clear();
        wait_cyc(2);
        vc0 = valid_cnt;
        for (int i = 0; i < 4; i++) begin
            apply_tick(24'h200000, 24'h100000, 24'h400000, 24'hC00000, 1'b1, 1'b0, 1'b0);
            wait_cyc(9);
        end
        check("post_reset_valid_count", W'(valid_cnt - vc0), W'(1));

        // Rounding: mean of -2^-2 LSB
        for (int i = 0; i < 4; i++) begin
            apply_tick(24'hFFFFFF, 24'h000000, 24'h400000, 24'h000000, 1'b1, 1'b0, 1'b0);
            wait_cyc(9);
        end
`ifdef LOCKIN_ROUND_EN
        check("round_slot0", W'(bus.iq_o[NB-1:0]), W'(24'h000000));
`else
        check("round_slot0", W'(bus.iq_o[NB-1:0]), W'(24'hFFFFFF));
`endif

        // Overrun: second tick 3 cycles later is dropped
        apply_tick(24'h100000, 24'h080000, 24'h400000, 24'h200000, 1'b1, 1'b0, 1'b0);
        wait_cyc(2);
        apply_tick(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0, 1'b0, 1'b0);
        check("overrun_set", W'(bus.overrun_o), W'(1));
        wait_cyc(10);
        for (int i = 0; i < 3; i++) begin
            apply_tick(24'h100000, 24'h080000, 24'h400000, 24'h200000, 1'b1, 1'b0, 1'b0);
            wait_cyc(9);
        end
        check("overrun_sticky", W'(bus.overrun_o), W'(1));
        pulse_clear();
        check("overrun_cleared", W'(bus.overrun_o), '0);
        apply_tick(24'h010000, 24'h020000, 24'h400000, 24'h400000, 1'b1, 1'b0, 1'b0);
        wait_cyc(2);
        apply_tick(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0, 1'b0, 1'b1);
        check("overrun_set_beats_clear", W'(bus.overrun_o), W'(1));
        wait_cyc(10);
        pulse_clear();
        check("overrun_cleared_again", W'(bus.overrun_o), '0);

        // sync aborts a partial decimation
        pulse_sync();
        wait_cyc(2);
        vc0 = valid_cnt;
        for (int i = 0; i < 2; i++) begin
            apply_tick(24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 1'b1, 1'b0, 1'b0);
            wait_cyc(9);
        end
        pulse_sync();
        wait_cyc(10);
        check("sync_no_valid", W'(valid_cnt - vc0), '0);
        for (int i = 0; i < 4; i++) begin
            apply_tick(24'h300000, 24'hD00000, 24'h200000, 24'h600000, 1'b1, 1'b0, 1'b0);
            wait_cyc(9);
        end
        check("sync_fresh_valid", W'(valid_cnt - vc0), W'(1));

        // sync coincident with tick: tick dropped, no overrun
        apply_tick(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0, 1'b1, 1'b0);
        model_clear();
        check("sync_tick_no_overrun", W'(bus.overrun_o), '0);
        check("sync_tick_not_busy", W'(bus.busy_o), '0);
        wait_cyc(9);
        for (int i = 0; i < 4; i++) begin
            apply_tick(24'h123456, 24'hFEDCBA, 24'h654321, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
            wait_cyc(9);
        end

        // Back-to-back at minimum spacing with random data
        pulse_sync();
        wait_cyc(2);
        vc0 = valid_cnt;
        for (int i = 0; i < 64; i++) begin
            r0 = NB'($urandom());
            r1 = NB'($urandom());
            rs = NB'($urandom());
            rc = NB'($urandom());
            apply_tick(r0, r1, rs, rc, 1'b1, 1'b0, 1'b0);
            wait_cyc(LAT - 1);
        end
        wait_cyc(20);
        check("b2b_no_overrun", W'(bus.overrun_o), '0);
        check("b2b_valid_count", W'(valid_cnt - vc0), W'(16));
        check("queue_drained", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
